// File: rtl/spike_rate_decoder_if.sv
// Result handshake bundle between spike_rate_decoder (master) and the readout logic (slave).
// The first-spike latency fields exist only when SPIKE_DEC_LATENCY_EN is defined.
interface spike_rate_decoder_if #(
  parameter int CNT_W = 10
`ifdef SPIKE_DEC_LATENCY_EN
  , parameter int WIN_W = 10
`endif
);

  logic [CNT_W-1:0] result_count;
  logic             result_fire;
  logic             result_valid;
  logic             result_ready;
  logic             overrun;
`ifdef SPIKE_DEC_LATENCY_EN
  logic [WIN_W-1:0] first_latency;
  logic             no_spike;
`endif

  modport master (
    output result_count,
    output result_fire,
    output result_valid,
    output overrun,
`ifdef SPIKE_DEC_LATENCY_EN
    output first_latency,
    output no_spike,
`endif
    input  result_ready
  );

  modport slave (
    input  result_count,
    input  result_fire,
    input  result_valid,
    input  overrun,
`ifdef SPIKE_DEC_LATENCY_EN
    input  first_latency,
    input  no_spike,
`endif
    output result_ready
  );

endinterface

// File: rtl/spike_rate_decoder.sv
// Counts rising edges of spike_in over gapless WINDOW-cycle windows and offers each count
// plus a threshold class over a valid/ready handshake. Optional macro: SPIKE_DEC_LATENCY_EN.
module spike_rate_decoder #(
  parameter int WINDOW    = 1024,
  parameter int CNT_W     = 10,
  parameter int THRESHOLD = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                spike_in,
  input  logic                enable,
  output logic                busy,
  spike_rate_decoder_if.master res
);

  localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;

  localparam logic [0:0]       ST_IDLE  = 1'b0;
  localparam logic [0:0]       ST_COUNT = 1'b1;

  localparam logic [WIN_W-1:0] LAST_C   = WIN_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] THR_C    = CNT_W'(THRESHOLD);

  logic [0:0]       state_r;
  logic             busy_r;
  logic             spike_d_r;
  logic [WIN_W-1:0] cyc_r;
  logic [CNT_W-1:0] acc_r;
  logic [CNT_W-1:0] count_r;
  logic             fire_r;
  logic             valid_r;
  logic             overrun_r;

  logic             spike_s;
  logic             last_cyc_s;
  logic             win_done_s;
  logic             consume_s;
  logic             load_s;
  logic             drop_s;
  logic [CNT_W-1:0] acc_next_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    if (inc && (v != CNT_MAX)) begin
      sat_inc = v + CNT_W'(1'b1);
    end else begin
      sat_inc = v;
    end
  endfunction

  assign spike_s    = spike_in & ~spike_d_r;
  assign last_cyc_s = (cyc_r == LAST_C);
  assign win_done_s = (state_r == ST_COUNT) && enable && last_cyc_s;
  assign acc_next_s = sat_inc(acc_r, spike_s);
  assign consume_s  = valid_r && res.result_ready;
  // A completing window is accepted when the slot is empty or being emptied this edge.
  assign load_s     = win_done_s && (!valid_r || consume_s);
  assign drop_s     = win_done_s && valid_r && !consume_s;

  // Previous spike level for rising-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      spike_d_r <= 1'b0;
    end else begin
      spike_d_r <= spike_in;
    end
  end

  // Window sequencing: state, cycle index within window, spike accumulator.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      cyc_r   <= {WIN_W{1'b0}};
      acc_r   <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          cyc_r <= {WIN_W{1'b0}};
          acc_r <= {CNT_W{1'b0}};
          if (enable) begin
            state_r <= ST_COUNT;
            busy_r  <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        ST_COUNT: begin
          if (!enable) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            cyc_r   <= {WIN_W{1'b0}};
            acc_r   <= {CNT_W{1'b0}};
          end else if (last_cyc_s) begin
            state_r <= ST_COUNT;
            busy_r  <= 1'b1;
            cyc_r   <= {WIN_W{1'b0}};
            acc_r   <= {CNT_W{1'b0}};
          end else begin
            state_r <= ST_COUNT;
            busy_r  <= 1'b1;
            cyc_r   <= cyc_r + WIN_W'(1'b1);
            acc_r   <= acc_next_s;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          cyc_r   <= {WIN_W{1'b0}};
          acc_r   <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // Result slot: load, hold until consumed, sticky overrun on a dropped window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r   <= {CNT_W{1'b0}};
      fire_r    <= 1'b0;
      valid_r   <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      if (load_s) begin
        count_r <= acc_next_s;
        fire_r  <= (acc_next_s >= THR_C);
        valid_r <= 1'b1;
      end else if (consume_s) begin
        valid_r <= 1'b0;
      end else begin
        valid_r <= valid_r;
      end
      if (drop_s) begin
        overrun_r <= 1'b1;
      end else begin
        overrun_r <= overrun_r;
      end
    end
  end

`ifdef SPIKE_DEC_LATENCY_EN
  logic             seen_r;
  logic [WIN_W-1:0] lat_r;
  logic [WIN_W-1:0] first_lat_r;
  logic             no_spike_r;
  logic [WIN_W-1:0] first_lat_s;
  logic             no_spike_s;

  assign first_lat_s = seen_r ? lat_r : (spike_s ? cyc_r : LAST_C);
  assign no_spike_s  = ~(seen_r | spike_s);

  // Index of the first detected edge in the running window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seen_r <= 1'b0;
      lat_r  <= {WIN_W{1'b0}};
    end else if ((state_r == ST_COUNT) && enable && !last_cyc_s) begin
      if (spike_s && !seen_r) begin
        seen_r <= 1'b1;
        lat_r  <= cyc_r;
      end else begin
        seen_r <= seen_r;
        lat_r  <= lat_r;
      end
    end else begin
      seen_r <= 1'b0;
      lat_r  <= {WIN_W{1'b0}};
    end
  end

  // Latency result shares the load/hold/drop behaviour of result_count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      first_lat_r <= {WIN_W{1'b0}};
      no_spike_r  <= 1'b0;
    end else if (load_s) begin
      first_lat_r <= first_lat_s;
      no_spike_r  <= no_spike_s;
    end else begin
      first_lat_r <= first_lat_r;
      no_spike_r  <= no_spike_r;
    end
  end

  assign res.first_latency = first_lat_r;
  assign res.no_spike      = no_spike_r;
`endif

  assign res.result_count = count_r;
  assign res.result_fire  = fire_r;
  assign res.result_valid = valid_r;
  assign res.overrun      = overrun_r;
  assign busy             = busy_r;

endmodule

// File: doc/spike_rate_decoder.md
Name: spike_rate_decoder

Overview:
- Reads the binary spike train produced by the output neuron and converts it to a rate code.
- Counts rising edges of the spike input over fixed windows of WINDOW clock cycles, then compares each count against THRESHOLD to give a fire/no-fire class.
- Hands each window's result to the JTAG readout logic over a valid/ready handshake.
- Sits between the network's neuron_out and the host interface, on the same clk as the network.

Parameters:
- WINDOW, 1024, window length in clk cycles (>= 2).
- CNT_W, 10, width of spike count; count saturates at 2^CNT_W-1.
- THRESHOLD, 8, minimum spike count for result_fire = 1.
- WIN_W, $clog2(WINDOW), width of internal cycle counter (derived, not overridden).

Ports:
- clk  input  1  system clock, same domain as network.
- rst  input  1  reset, asynchronous, active-low.
- spike_in  input  1  binary neuron output; synchronous to clk.
- enable  input  1  high = decode windows back-to-back; low = idle.
- result_count  output  CNT_W  spike count of last completed window.
- result_fire  output  1  result_count >= THRESHOLD.
- result_valid  output  1  result registers hold an unconsumed result.
- result_ready  input  1  consumer accepts result when high with result_valid.
- overrun  output  1  sticky: a completed window was dropped.
- busy  output  1  high while in COUNT state.

Behaviour:
- Reset (rst low, async): all outputs 0; internal spike_d, cycle counter, accumulator 0; state IDLE. Mid-window reset discards the partial window and any pending result.
- Edge detect: spike = spike_in & ~spike_d; spike_d <= spike_in every cycle. A level held high counts once.
- States:
  - IDLE: cycle counter and accumulator held at 0; busy = 0. enable high -> COUNT. The first window cycle is the cycle after enable is sampled high.
  - COUNT: busy = 1; cycle counter increments 0..WINDOW-1. Each spike adds 1 to the accumulator, saturating at 2^CNT_W-1.
    - On cycle WINDOW-1, a spike in that cycle is included.
    - The final value goes to the result path, and the accumulator and counter clear for the next window.
    - State stays COUNT; windows are gapless.
  - enable low in COUNT: partial window discarded; -> IDLE next cycle; a pending result is retained.
- Result load: result_count, result_fire and result_valid update on the clock edge after the final window cycle (latency 1).
- Handshake:
  - result_valid && result_ready at an edge: the result is consumed and result_valid falls at that edge, unless a new result loads the same edge.
  - Result registers are stable while result_valid is high and not consumed.
- Overrun:
  - A window completes while result_valid is high and not consumed that cycle: the new result is dropped, old result kept, overrun <= 1. overrun is sticky until rst.
  - Simultaneous completion and consumption: the new result loads, result_valid stays 1, no overrun.
- result_fire is computed from the saturated count with CNT_W-bit unsigned compare. THRESHOLD = 0 gives fire always 1.

Optional Feature:
- Macro SPIKE_DEC_LATENCY_EN.
- Defined:
  - Adds output first_latency [WIN_W-1:0]: cycle index within the window of the first counted spike.
  - Value is WINDOW-1 with no_spike = 1 (extra 1-bit output) if no spike occurred.
  - Loaded, held and dropped together with result_count under the same handshake/overrun rules; reset 0, no_spike reset 0.
- Undefined: neither port nor tracking logic exists; behaviour is otherwise identical.

Test Plan:
- Single spike (WINDOW=16, THRESHOLD=3):
  - Stimulus: rst low 3 cycles, enable=1, result_ready=1, one 1-cycle spike at window cycle 5.
  - Required: result_count=1, result_fire=0, result_valid high for exactly 1 cycle, 17 cycles after enable sampled.
- Threshold and level counting (WINDOW=16, THRESHOLD=3):
  - Stimulus: spike_in toggles every cycle for a whole window; then spike_in held high 10 cycles.
  - Required: first window count=8, fire=1; the held level counts 1.
- Saturation (CNT_W=3, WINDOW=32):
  - Stimulus: alternating spike_in gives 16 edges.
  - Required: result_count=7, fire per THRESHOLD.
- Overrun (WINDOW=16):
  - Stimulus: result_ready=0 across two window completions.
  - Required: first result held unchanged; overrun=1 after second completion. Raise ready: consumed, result_valid=0; overrun stays 1 until rst.
- Simultaneous completion and consume:
  - Stimulus: ready asserted exactly on the completing cycle of the next window.
  - Required: new result visible next cycle, result_valid stays 1, overrun=0.
- Mid-window abort and reset:
  - Stimulus: enable drops at window cycle 9.
  - Required: no result, busy=0 next cycle; re-enable gives a full fresh window. Async rst mid-window clears all outputs immediately.
